// File: rtl/mw_pipe_stage.sv
// MEM/WB-class pipeline stage register: valid/ready handshake, flush, x0-write suppression, sticky halt.
// Optional build macro MW_PIPE_SKID_EN adds one skid entry so that in_ready comes from registered state only.
module mw_pipe_stage #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb_en,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb_en,
  output logic              out_halt,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [RD_W-1:0]   out_rd_r;
  logic              out_wb_r;
  logic              out_halt_r;
  logic              halted_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              skid_valid_s;
  logic              skid_halt_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              hold_halt_s;
  logic              cap_wb_s;
  logic              in_ready_s;

  // Next-beat selection for the output register
  logic              ld_out_s;
  logic              clr_out_s;
  logic [DATA_W-1:0] ld_data_s;
  logic [RD_W-1:0]   ld_rd_s;
  logic              ld_wb_s;
  logic              ld_halt_s;

  // A write to x0 is dropped at capture so it can never reach the register file
  assign cap_wb_s    = in_wb_en & (in_rd != {RD_W{1'b0}});
  assign in_fire_s   = in_valid & in_ready_s;
  assign out_fire_s  = out_valid_r & out_ready;
  assign hold_halt_s = (out_valid_r & out_halt_r) | skid_halt_s;

`ifdef MW_PIPE_SKID_EN
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [RD_W-1:0]   skid_rd_r;
  logic              skid_wb_r;
  logic              skid_halt_r;

  assign skid_valid_s = skid_valid_r;
  assign skid_halt_s  = skid_valid_r & skid_halt_r;

  // Ready from registered state only; the skid absorbs the beat accepted during a stall
  always_comb begin
    in_ready_s = !halted_r & !hold_halt_s & !skid_valid_s;
  end

  // Skid entry: filled when the output is stalled, drained into the output on out_fire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
      skid_rd_r    <= {RD_W{1'b0}};
      skid_wb_r    <= 1'b0;
      skid_halt_r  <= 1'b0;
    end else if (flush) begin
      skid_valid_r <= 1'b0;
    end else if (out_fire_s && skid_valid_r) begin
      skid_valid_r <= 1'b0;
    end else if (in_fire_s && out_valid_r && !out_fire_s) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= in_data;
      skid_rd_r    <= in_rd;
      skid_wb_r    <= cap_wb_s;
      skid_halt_r  <= in_halt;
    end
  end

  // Output register takes the skid beat first so ordering is preserved
  always_comb begin
    ld_out_s  = 1'b0;
    clr_out_s = 1'b0;
    ld_data_s = in_data;
    ld_rd_s   = in_rd;
    ld_wb_s   = cap_wb_s;
    ld_halt_s = in_halt;
    if (out_fire_s && skid_valid_r) begin
      ld_out_s  = 1'b1;
      ld_data_s = skid_data_r;
      ld_rd_s   = skid_rd_r;
      ld_wb_s   = skid_wb_r;
      ld_halt_s = skid_halt_r;
    end else if (in_fire_s && (!out_valid_r || out_fire_s)) begin
      ld_out_s = 1'b1;
    end else if (out_fire_s) begin
      clr_out_s = 1'b1;
    end else begin
      ld_out_s  = 1'b0;
    end
  end
`else
  assign skid_valid_s = 1'b0;
  assign skid_halt_s  = 1'b0;

  // Combinational ready: a stalled output can still take a beat when downstream drains it
  always_comb begin
    in_ready_s = !halted_r & !hold_halt_s & (!out_valid_r | out_ready);
  end

  // Output register loads on acceptance, empties when its beat leaves unreplaced
  always_comb begin
    ld_out_s  = 1'b0;
    clr_out_s = 1'b0;
    ld_data_s = in_data;
    ld_rd_s   = in_rd;
    ld_wb_s   = cap_wb_s;
    ld_halt_s = in_halt;
    if (in_fire_s && (!out_valid_r || out_fire_s)) begin
      ld_out_s = 1'b1;
    end else if (out_fire_s) begin
      clr_out_s = 1'b1;
    end else begin
      ld_out_s  = 1'b0;
    end
  end
`endif

  // Output register; payload is kept when valid drops, flush only kills the valid bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_rd_r    <= {RD_W{1'b0}};
      out_wb_r    <= 1'b0;
      out_halt_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (ld_out_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= ld_data_s;
      out_rd_r    <= ld_rd_s;
      out_wb_r    <= ld_wb_s;
      out_halt_r  <= ld_halt_s;
    end else if (clr_out_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky halt: a halt beat handed downstream counts even in a flush cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_r <= 1'b0;
    end else if (out_fire_s && out_halt_r) begin
      halted_r <= 1'b1;
    end
  end

  // Saturating back-pressure counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && !out_ready && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_rd    = out_rd_r;
  assign out_wb_en = out_wb_r & out_valid_r;
  assign out_halt  = out_halt_r & out_valid_r;
  assign halted    = halted_r;
  assign stall_cnt = stall_cnt_r;

endmodule
